// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: FSM states, NOP encoding, HLT opcode
// and the PC increment.
package fetch_pkg;

   typedef enum logic [1:0] {
      StFetch,
      StDiscard,
      StHaltPend,
      StHalted
   } fetch_state_e;

   localparam logic [15:0] NOP_INSTR = 16'h0000;
   localparam logic [3:0]  OPC_HLT   = 4'b1111;
   localparam logic [15:0] PC_INC    = 16'd2;

   function automatic logic is_hlt(input logic [15:0] instr);
      return instr[15:12] == OPC_HLT;
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc_plus2} holding buffer for a fetch word that returns while IF/ID is
// stalled. Clear has priority over load.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  logic [15:0] load_instr,
   input  logic [15:0] load_pc_plus2,
   output logic        full,
   output logic [15:0] instr,
   output logic [15:0] pc_plus2
);

   logic        full_q;
   logic [15:0] instr_q;
   logic [15:0] pc_plus2_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         full_q <= 1'b0;
      end else if (load) begin
         full_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= 16'h0000;
      end else if (load) begin
         instr_q    <= load_instr;
         pc_plus2_q <= load_pc_plus2;
      end
   end

   assign full     = full_q;
   assign instr    = instr_q;
   assign pc_plus2 = pc_plus2_q;

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch-side control: PC, instruction-memory read handshake and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating stall-cycle and flush-event counters.
module fetch_stage_ctrl
   import fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        hlt_in,
   input  logic        flush,
   input  logic [15:0] br_target,
   output logic        imem_rd_en,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_instr,
   input  logic        imem_valid,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_plus2,
   output logic        if_id_valid,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
`endif
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic [15:0]  hold_addr_q, hold_addr_d;
   logic [15:0]  if_instr_q, if_instr_d;
   logic [15:0]  if_pc2_q, if_pc2_d;
   logic         if_valid_q, if_valid_d;
   logic         skid_load, skid_clear, skid_full;
   logic [15:0]  skid_instr, skid_pc2;
   logic [15:0]  pc_plus2;
   logic         resp;

   assign pc_plus2 = pc_q + PC_INC;
   // A response only counts against a request we actually issued.
   assign resp     = imem_valid & imem_rd_en;

   fetch_skid_buf u_skid (
      .clk          (clk),
      .rst          (rst),
      .load         (skid_load),
      .clear        (skid_clear),
      .load_instr   (imem_instr),
      .load_pc_plus2(pc_plus2),
      .full         (skid_full),
      .instr        (skid_instr),
      .pc_plus2     (skid_pc2)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (hlt_in) begin
         state_d = StHalted;
      end else begin
         unique case (state_q)
            StFetch: begin
               if (flush) begin
                  state_d = (imem_rd_en && !imem_valid) ? StDiscard : StFetch;
               end else if (!stall) begin
                  if ((skid_full && is_hlt(skid_instr)) || (resp && is_hlt(imem_instr))) begin
                     state_d = StHaltPend;
                  end
               end
            end
            StDiscard: begin
               if (imem_valid) begin
                  state_d = StFetch;
               end
            end
            StHaltPend: begin
               if (flush) begin
                  state_d = StFetch;
               end
            end
            StHalted: state_d = StHalted;
         endcase
      end
   end

   always_comb begin
      imem_rd_en = 1'b0;
      imem_addr  = pc_q;
      halted     = 1'b0;
      unique case (state_q)
         StFetch:    imem_rd_en = !rst && !skid_full;
         StDiscard: begin
            imem_rd_en = !rst;
            imem_addr  = hold_addr_q;
         end
         StHaltPend: imem_rd_en = 1'b0;
         StHalted:   halted     = 1'b1;
      endcase
   end

   always_comb begin
      pc_d        = pc_q;
      hold_addr_d = hold_addr_q;
      if_instr_d  = if_instr_q;
      if_pc2_d    = if_pc2_q;
      if_valid_d  = if_valid_q;
      skid_load   = 1'b0;
      skid_clear  = 1'b0;
      if (hlt_in || state_q == StHalted) begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
         skid_clear = 1'b1;
      end else if (flush) begin
         pc_d       = br_target;
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
         skid_clear = 1'b1;
         // In DISCARD the outstanding address is already latched and must stay put.
         if (state_q != StDiscard) begin
            hold_addr_d = pc_q;
         end
      end else if (stall) begin
         skid_load = (state_q == StFetch) && resp;
      end else if (state_q == StFetch && skid_full) begin
         if_instr_d = skid_instr;
         if_pc2_d   = skid_pc2;
         if_valid_d = 1'b1;
         skid_clear = 1'b1;
         pc_d       = pc_plus2;
      end else if (state_q == StFetch && resp) begin
         if_instr_d = imem_instr;
         if_pc2_d   = pc_plus2;
         if_valid_d = 1'b1;
         pc_d       = pc_plus2;
      end else begin
         if_instr_d = NOP_INSTR;
         if_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         hold_addr_q <= RESET_PC;
         if_instr_q  <= NOP_INSTR;
         if_pc2_q    <= 16'h0000;
         if_valid_q  <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         hold_addr_q <= hold_addr_d;
         if_instr_q  <= if_instr_d;
         if_pc2_q    <= if_pc2_d;
         if_valid_q  <= if_valid_d;
      end
   end

   assign if_id_instr    = if_instr_q;
   assign if_id_pc_plus2 = if_pc2_q;
   assign if_id_valid    = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 16'h0000;
         flush_count_q  <= 16'h0000;
      end else begin
         if (stall && !halted && stall_cycles_q != 16'hFFFF) begin
            stall_cycles_q <= stall_cycles_q + 16'd1;
         end
         if (flush && !halted && flush_count_q != 16'hFFFF) begin
            flush_count_q <= flush_count_q + 16'd1;
         end
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed self-checking bench for fetch_stage_ctrl with a latency-programmable memory model.
module tb_fetch_stage_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        hlt_in;
   logic        flush;
   logic [15:0] br_target;
   logic        imem_rd_en;
   logic [15:0] imem_addr;
   logic [15:0] imem_instr;
   logic        imem_valid;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_plus2;
   logic        if_id_valid;
   logic        halted;

   logic [15:0] mem [64];
   logic [7:0]  lat;
   logic [7:0]  wait_cnt;
   int          n_checks;
   int          n_fail;

   fetch_stage_ctrl #(.RESET_PC(16'h0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .hlt_in        (hlt_in),
      .flush         (flush),
      .br_target     (br_target),
      .imem_rd_en    (imem_rd_en),
      .imem_addr     (imem_addr),
      .imem_instr    (imem_instr),
      .imem_valid    (imem_valid),
      .if_id_instr   (if_id_instr),
      .if_id_pc_plus2(if_id_pc_plus2),
      .if_id_valid   (if_id_valid),
      .halted        (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory answers once the request has been held for lat cycles (lat 0 = same cycle).
   always_comb begin
      imem_instr = mem[imem_addr[6:1]];
      imem_valid = imem_rd_en && (wait_cnt >= lat);
   end

   always_ff @(posedge clk) begin
      if (imem_rd_en && !imem_valid) wait_cnt <= wait_cnt + 8'd1;
      else wait_cnt <= 8'd0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; stall = 1'b0; hlt_in = 1'b0; flush = 1'b0; br_target = 16'h0000; lat = 8'd0;
      tick();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; hlt_in = 1'b0; flush = 1'b0; br_target = 16'h0000; lat = 8'd0;
      tick();
      tick();
      n_checks++; if (if_id_instr !== 16'h0000) begin n_fail++;
         $display("FAIL rst_instr: got %h want 0000", if_id_instr); end
      n_checks++; if (if_id_pc_plus2 !== 16'h0000) begin n_fail++;
         $display("FAIL rst_pc2: got %h want 0000", if_id_pc_plus2); end
      n_checks++; if (if_id_valid !== 1'b0) begin n_fail++;
         $display("FAIL rst_valid: got %b want 0", if_id_valid); end
      n_checks++; if (halted !== 1'b0) begin n_fail++;
         $display("FAIL rst_halted: got %b want 0", halted); end
      n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++;
         $display("FAIL rst_rd_en: got %b want 0", imem_rd_en); end
      rst = 1'b0;
      #1;
      n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++;
         $display("FAIL rst_first_req: got rd_en %b addr %h want 1 0000", imem_rd_en, imem_addr); end
   endtask

   task automatic test_zero_wait();
      tick();
      n_checks++; if (if_id_instr !== 16'h1234 || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1)
         begin n_fail++; $display("FAIL zw_first: got %h/%h/%b want 1234/0002/1",
         if_id_instr, if_id_pc_plus2, if_id_valid); end
      tick();
      n_checks++; if (if_id_instr !== 16'h5678 || if_id_pc_plus2 !== 16'h0004 || if_id_valid !== 1'b1)
         begin n_fail++; $display("FAIL zw_second: got %h/%h/%b want 5678/0004/1",
         if_id_instr, if_id_pc_plus2, if_id_valid); end
   endtask

   task automatic test_wait_states();
      apply_reset();
      lat = 8'd3;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++;
            $display("FAIL ws_hold%0d: got rd_en %b addr %h want 1 0000", i, imem_rd_en, imem_addr); end
         tick();
         n_checks++; if (if_id_valid !== 1'b0) begin n_fail++;
            $display("FAIL ws_bubble%0d: got valid %b want 0", i, if_id_valid); end
      end
      tick();
      n_checks++; if (if_id_instr !== 16'h1234 || if_id_pc_plus2 !== 16'h0002 || if_id_valid !== 1'b1)
         begin n_fail++; $display("FAIL ws_data: got %h/%h/%b want 1234/0002/1",
         if_id_instr, if_id_pc_plus2, if_id_valid); end
      lat = 8'd0;
   endtask

   task automatic test_stall_skid();
      apply_reset();
      tick(); tick(); tick();
      stall = 1'b1;
      tick();
      n_checks++; if (if_id_instr !== 16'h2222 || if_id_pc_plus2 !== 16'h0006) begin n_fail++;
         $display("FAIL sk_hold: got %h/%h want 2222/0006", if_id_instr, if_id_pc_plus2); end
      n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++;
         $display("FAIL sk_rd_en: got %b want 0", imem_rd_en); end
      tick();
      stall = 1'b0;
      n_checks++; if (if_id_instr !== 16'h2222) begin n_fail++;
         $display("FAIL sk_hold2: got %h want 2222", if_id_instr); end
      tick();
      n_checks++; if (if_id_instr !== 16'hAAAA || if_id_pc_plus2 !== 16'h0008 || if_id_valid !== 1'b1)
         begin n_fail++; $display("FAIL sk_release: got %h/%h/%b want aaaa/0008/1",
         if_id_instr, if_id_pc_plus2, if_id_valid); end
      n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0008) begin n_fail++;
         $display("FAIL sk_reissue: got rd_en %b addr %h want 1 0008", imem_rd_en, imem_addr); end
      tick();
      n_checks++; if (if_id_instr !== 16'h3333 || if_id_pc_plus2 !== 16'h000A) begin n_fail++;
         $display("FAIL sk_next: got %h/%h want 3333/000a", if_id_instr, if_id_pc_plus2); end
   endtask

   task automatic test_flush_discard();
      apply_reset();
      repeat (5) tick();
      lat = 8'd2; flush = 1'b1; br_target = 16'h0040;
      tick();
      flush = 1'b0;
      n_checks++; if (if_id_instr !== 16'h0000 || if_id_valid !== 1'b0) begin n_fail++;
         $display("FAIL fd_nop: got %h/%b want 0000/0", if_id_instr, if_id_valid); end
      n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h000A) begin n_fail++;
         $display("FAIL fd_hold: got rd_en %b addr %h want 1 000a", imem_rd_en, imem_addr); end
      tick();
      n_checks++; if (imem_addr !== 16'h000A) begin n_fail++;
         $display("FAIL fd_hold2: got addr %h want 000a", imem_addr); end
      tick();
      n_checks++; if (if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) begin n_fail++;
         $display("FAIL fd_drop: got %h/%b want 0000/0", if_id_instr, if_id_valid); end
      n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++;
         $display("FAIL fd_target: got rd_en %b addr %h want 1 0040", imem_rd_en, imem_addr); end
      lat = 8'd0;
      tick();
      n_checks++; if (if_id_instr !== 16'h4444 || if_id_pc_plus2 !== 16'h0042) begin n_fail++;
         $display("FAIL fd_first: got %h/%h want 4444/0042", if_id_instr, if_id_pc_plus2); end
   endtask

   task automatic test_halt_flush();
      mem[0] = 16'hF000;
      apply_reset();
      tick();
      flush = 1'b1; br_target = 16'h0040;
      n_checks++; if (imem_rd_en !== 1'b0) begin n_fail++;
         $display("FAIL hf_pend: got rd_en %b want 0", imem_rd_en); end
      tick();
      flush = 1'b0;
      n_checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++;
         $display("FAIL hf_redirect: got rd_en %b addr %h want 1 0040", imem_rd_en, imem_addr); end
      tick();
      n_checks++; if (if_id_instr !== 16'h4444 || if_id_pc_plus2 !== 16'h0042) begin n_fail++;
         $display("FAIL hf_fetch: got %h/%h want 4444/0042", if_id_instr, if_id_pc_plus2); end
   endtask

   task automatic test_halt();
      apply_reset();
      tick();
      n_checks++; if (if_id_instr !== 16'hF000 || if_id_valid !== 1'b1 || imem_rd_en !== 1'b0)
         begin n_fail++; $display("FAIL ht_hlt: got %h/%b rd_en %b want f000/1 0",
         if_id_instr, if_id_valid, imem_rd_en); end
      tick();
      n_checks++; if (imem_rd_en !== 1'b0 || halted !== 1'b0) begin n_fail++;
         $display("FAIL ht_pend: got rd_en %b halted %b want 0 0", imem_rd_en, halted); end
      hlt_in = 1'b1;
      tick();
      hlt_in = 1'b0;
      n_checks++; if (halted !== 1'b1 || if_id_instr !== 16'h0000 || if_id_valid !== 1'b0)
         begin n_fail++; $display("FAIL ht_halted: got halted %b %h/%b want 1 0000/0",
         halted, if_id_instr, if_id_valid); end
      flush = 1'b1; br_target = 16'h0040;
      tick(); tick();
      flush = 1'b0;
      n_checks++; if (halted !== 1'b1 || imem_rd_en !== 1'b0) begin n_fail++;
         $display("FAIL ht_sticky: got halted %b rd_en %b want 1 0", halted, imem_rd_en); end
      mem[0] = 16'h1234;
   endtask

   task automatic test_flush_stall_wrap();
      apply_reset();
      flush = 1'b1; br_target = 16'hFFFE;
      tick();
      n_checks++; if (imem_addr !== 16'hFFFE || if_id_valid !== 1'b0) begin n_fail++;
         $display("FAIL fw_redirect: got addr %h valid %b want fffe 0", imem_addr, if_id_valid); end
      stall = 1'b1; br_target = 16'h0040;
      tick();
      flush = 1'b0; stall = 1'b0;
      n_checks++; if (imem_addr !== 16'h0040 || if_id_valid !== 1'b0) begin n_fail++;
         $display("FAIL fw_flush_wins: got addr %h valid %b want 0040 0", imem_addr, if_id_valid); end
      apply_reset();
      flush = 1'b1; br_target = 16'hFFFE;
      tick();
      flush = 1'b0;
      tick();
      n_checks++; if (if_id_instr !== 16'h5555 || if_id_pc_plus2 !== 16'h0000) begin n_fail++;
         $display("FAIL fw_wrap: got %h/%h want 5555/0000", if_id_instr, if_id_pc_plus2); end
      n_checks++; if (imem_addr !== 16'h0000) begin n_fail++;
         $display("FAIL fw_wrap_addr: got %h want 0000", imem_addr); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int i = 0; i < 64; i++) mem[i] = {4'h1, 6'h00, i[5:0]};
      mem[0]  = 16'h1234;
      mem[1]  = 16'h5678;
      mem[2]  = 16'h2222;
      mem[3]  = 16'hAAAA;
      mem[4]  = 16'h3333;
      mem[5]  = 16'h7777;
      mem[32] = 16'h4444;
      mem[63] = 16'h5555;
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall_skid();
      test_flush_discard();
      test_halt_flush();
      test_halt();
      test_flush_stall_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
